// File: rtl/gf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_pkg : GF(2^13) constants and polynomial-basis helper functions   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gf_pkg;

  localparam int              GF_M    = 13;
  localparam logic [GF_M-1:0] GF_POLY = 13'h001B;
  localparam int              GF_PW   = 2 * GF_M - 1;

  // Folds x^k (k >= m) back into the field as x^(k-m) * poly, top bit first.
  function automatic logic [GF_M-1:0] gf_reduce(input logic [GF_PW-1:0] p_in,
                                                input logic [GF_M-1:0]  poly);
    logic [GF_PW-1:0] p;
    p = p_in;
    for (int k = GF_PW - 1; k >= GF_M; k--) begin
      if (p[k]) begin
        p[k] = 1'b0;
        p[k-GF_M +: GF_M] = p[k-GF_M +: GF_M] ^ poly;
      end
    end
    return p[GF_M-1:0];
  endfunction

  function automatic logic [GF_M-1:0] gf_mul(input logic [GF_M-1:0] a,
                                             input logic [GF_M-1:0] b);
    logic [GF_PW-1:0] p;
    p = '0;
    for (int i = 0; i < GF_M; i++) begin
      if (b[i]) p = p ^ (GF_PW'(a) << i);
    end
    return gf_reduce(p, GF_POLY);
  endfunction

  function automatic logic [GF_M-1:0] gf_sq_p(input logic [GF_M-1:0] a,
                                              input logic [GF_M-1:0] poly);
    logic [GF_PW-1:0] p;
    p = '0;
    for (int i = 0; i < GF_M; i++) p[2*i] = a[i];
    return gf_reduce(p, poly);
  endfunction

  function automatic logic [GF_M-1:0] gf_sq(input logic [GF_M-1:0] a);
    return gf_sq_p(a, GF_POLY);
  endfunction

  function automatic logic [GF_M-1:0] gf_sqn(input logic [GF_M-1:0] a, input int n);
    logic [GF_M-1:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = gf_sq(r);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_synd_arith_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_synd_arith_if : operand/result bundle of the syndrome arithmetic |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface gf_synd_arith_if #(
  parameter int m = 13,
  parameter int N = 20
);
  logic [m-1:0]   din_A;
  logic [m-1:0]   dout_A;
  logic           dout_en_A;
  logic [m-1:0]   din_B;
  logic [m-1:0]   dout_B;
  logic           dout_en_B;
  logic [m-1:0]   sq_din;
  logic [m-1:0]   sq_dout;
  logic [N*m-1:0] vector;
  logic [m-1:0]   res;

  modport master (
    output din_A, din_B, sq_din, vector,
    input  dout_A, dout_en_A, dout_B, dout_en_B, sq_dout, res
  );

  modport slave (
    input  din_A, din_B, sq_din, vector,
    output dout_A, dout_en_A, dout_B, dout_en_B, sq_dout, res
  );
endinterface
`default_nettype wire

// File: rtl/gf_inv_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_inv_core : combinational Itoh-Tsujii inverse in GF(2^13)         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gf_inv_core
  import gf_pkg::*;
(
  input  logic [GF_M-1:0] a_i,
  output logic [GF_M-1:0] inv_o
);

  // b<k> holds a^(2^k - 1); inv = (a^(2^12 - 1))^2 = a^(2^13 - 2), and 0 maps to 0.
  logic [GF_M-1:0] b2, b3, b6, b12;

  assign b2    = gf_mul(gf_sq(a_i), a_i);
  assign b3    = gf_mul(gf_sq(b2), a_i);
  assign b6    = gf_mul(gf_sqn(b3, 3), b3);
  assign b12   = gf_mul(gf_sqn(b6, 6), b6);
  assign inv_o = gf_sq(b12);

endmodule
`default_nettype wire

// File: rtl/gf_synd_arith.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gf_synd_arith : dual inverter, squarer and XOR reduction slice      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gf_synd_arith
  import gf_pkg::*;
#(
  parameter int           m     = 13,
  parameter int           N     = 20,
  parameter int           DELAY = 1,
  parameter logic [m-1:0] POLY  = 13'h001B
) (
  input  logic            clk,
  input  logic            rst,
  gf_synd_arith_if.slave  bus
);

  logic [m-1:0]     inv_a_d, inv_b_d, sq_d, res_d;
  logic [m-1:0]     pipe_a_q [DELAY];
  logic [m-1:0]     pipe_b_q [DELAY];
  logic [DELAY-1:0] en_a_q, en_b_q;
  logic [m-1:0]     sq_q;
  logic [m-1:0]     ent [N];

  gf_inv_core u_inv_a (.a_i(bus.din_A), .inv_o(inv_a_d));
  gf_inv_core u_inv_b (.a_i(bus.din_B), .inv_o(inv_b_d));

  assign sq_d = gf_sq_p(bus.sq_din, POLY);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_a_q[i] <= '0;
        pipe_b_q[i] <= '0;
      end
      en_a_q <= '0;
      en_b_q <= '0;
      sq_q   <= '0;
    end else begin
      pipe_a_q[0] <= inv_a_d;
      pipe_b_q[0] <= inv_b_d;
      en_a_q[0]   <= |bus.din_A;
      en_b_q[0]   <= |bus.din_B;
      for (int i = 1; i < DELAY; i++) begin
        pipe_a_q[i] <= pipe_a_q[i-1];
        pipe_b_q[i] <= pipe_b_q[i-1];
        en_a_q[i]   <= en_a_q[i-1];
        en_b_q[i]   <= en_b_q[i-1];
      end
      sq_q <= sq_d;
    end
  end

  assign bus.dout_A    = pipe_a_q[DELAY-1];
  assign bus.dout_B    = pipe_b_q[DELAY-1];
  assign bus.dout_en_A = en_a_q[DELAY-1];
  assign bus.dout_en_B = en_b_q[DELAY-1];
  assign bus.sq_dout   = sq_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ent
      assign ent[gi] = bus.vector[gi*m +: m];
    end
  endgenerate

  always_comb begin
    res_d = '0;
    for (int i = 0; i < N; i++) res_d = res_d ^ ent[i];
  end

  assign bus.res = res_d;

endmodule
`default_nettype wire

// File: tb/tb_gf_synd_arith.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gf_synd_arith : scoreboard bench for DELAY=1 and DELAY=3 copies  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_gf_synd_arith;

  localparam logic [12:0] P = 13'h001B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_synd_arith_if #(.m(13), .N(20)) bus1 ();
  gf_synd_arith_if #(.m(13), .N(20)) bus3 ();

  gf_synd_arith #(.m(13), .N(20), .DELAY(1), .POLY(P)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  gf_synd_arith #(.m(13), .N(20), .DELAY(3), .POLY(P)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [12:0] a_v = '0, b_v = '0, s_v = '0;
  logic [12:0] qa1[$], qb1[$], qa3[$], qb3[$], qs1[$], qs3[$];
  logic [259:0] vec;

  // MSB-first shift-and-add multiply, independent of the design's helpers.
  function automatic logic [12:0] tb_mul(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] r;
    r = '0;
    for (int i = 12; i >= 0; i--) begin
      r = {r[11:0], 1'b0} ^ (r[12] ? P : 13'h0000);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [12:0] tb_xor(input logic [259:0] v);
    logic [12:0] r;
    r = '0;
    for (int i = 0; i < 20; i++) r = r ^ v[i*13 +: 13];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv(input string tag, input logic [12:0] op,
                         input logic [12:0] dout, input logic en);
    if (op == 13'h0000) begin
      chk({tag, "_val"}, dout, 13'h0000);
      chk({tag, "_en"}, {12'b0, en}, 13'h0000);
    end else begin
      chk({tag, "_prod"}, tb_mul(op, dout), 13'h0001);
      chk({tag, "_en"}, {12'b0, en}, 13'h0001);
    end
  endtask

  task automatic apply();
    bus1.din_A = a_v;  bus3.din_A = a_v;
    bus1.din_B = b_v;  bus3.din_B = b_v;
    bus1.sq_din = s_v; bus3.sq_din = s_v;
  endtask

  task automatic chk_xor(input string tag, input logic [259:0] v, input logic [12:0] exp);
    bus1.vector = v;
    bus3.vector = v;
    #1;
    chk({tag, "_d1"}, bus1.res, exp);
    chk({tag, "_d3"}, bus3.res, exp);
  endtask

  // One clock: push expectations at the edge, pop and compare 1 time unit later.
  task automatic tick();
    apply();
    @(posedge clk);
    if (rst) begin
      qa1.delete(); qb1.delete(); qa3.delete(); qb3.delete(); qs1.delete(); qs3.delete();
      qa1.push_back(13'h0); qb1.push_back(13'h0);
      repeat (3) begin qa3.push_back(13'h0); qb3.push_back(13'h0); end
      qs1.push_back(13'h0); qs3.push_back(13'h0);
    end else begin
      qa1.push_back(a_v); qb1.push_back(b_v);
      qa3.push_back(a_v); qb3.push_back(b_v);
      qs1.push_back(tb_mul(s_v, s_v)); qs3.push_back(tb_mul(s_v, s_v));
    end
    #1;
    chk_inv("invA_d1", qa1.pop_front(), bus1.dout_A, bus1.dout_en_A);
    chk_inv("invB_d1", qb1.pop_front(), bus1.dout_B, bus1.dout_en_B);
    chk_inv("invA_d3", qa3.pop_front(), bus3.dout_A, bus3.dout_en_A);
    chk_inv("invB_d3", qb3.pop_front(), bus3.dout_B, bus3.dout_en_B);
    chk("sq_d1", bus1.sq_dout, qs1.pop_front());
    chk("sq_d3", bus3.sq_dout, qs3.pop_front());
  endtask

  initial begin
    vec = '0;
    bus1.vector = '0;
    bus3.vector = '0;
    apply();

    for (int i = 0; i < 20; i++) vec[i*13 +: 13] = 13'(i + 1);
    chk_xor("xor_seq", vec, 13'h0014);
    for (int i = 0; i < 20; i++) vec[i*13 +: 13] = 13'h1FFF;
    chk_xor("xor_ones", vec, 13'h0000);
    vec = '0;
    vec[19*13 +: 13] = 13'h0ABC;
    chk_xor("xor_last", vec, 13'h0ABC);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20; i++) vec[i*13 +: 13] = 13'($urandom);
      chk_xor("xor_rand", vec, tb_xor(vec));
    end

    rst = 1'b1;
    tick();
    tick();
    chk("rst_en_d3", {12'b0, bus3.dout_en_A}, 13'h0000);

    rst = 1'b0;
    a_v = 13'h0001; b_v = 13'h0002; s_v = 13'h0002;
    tick();
    chk("constA", bus1.dout_A, 13'h0001);
    chk("constEnA", {12'b0, bus1.dout_en_A}, 13'h0001);
    chk("constB", bus1.dout_B, 13'h100D);
    chk("sq_02", bus1.sq_dout, 13'h0004);

    a_v = 13'h0000; b_v = 13'h100D; s_v = 13'h0080;
    tick();
    chk("zeroA", bus1.dout_A, 13'h0000);
    chk("zeroEnA", {12'b0, bus1.dout_en_A}, 13'h0000);
    chk("invB_100D", bus1.dout_B, 13'h0002);
    chk("sq_80", bus1.sq_dout, 13'h0036);
    chk("d3_early", {12'b0, bus3.dout_en_A}, 13'h0000);

    a_v = 13'h0005; b_v = 13'h0007; s_v = 13'h1FFF;
    tick();
    chk("d3_latA", bus3.dout_A, 13'h0001);
    chk("d3_latEnA", {12'b0, bus3.dout_en_A}, 13'h0001);
    chk("d3_latB", bus3.dout_B, 13'h100D);
    chk("sq_1FFF", bus1.sq_dout, tb_mul(13'h1FFF, 13'h1FFF));

    for (int i = 1; i < 8192; i++) begin
      a_v = 13'(i);
      b_v = 13'(8192 - i);
      s_v = 13'(i);
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      a_v = 13'(i * 37 + 5);
      b_v = 13'(i * 101 + 3);
      s_v = 13'(i * 53 + 9);
      rst = (i == 5);
      tick();
      if (i == 5) begin
        chk("flush_A_d1", bus1.dout_A, 13'h0000);
        chk("flush_B_d3", bus3.dout_B, 13'h0000);
        chk("flush_enB_d1", {12'b0, bus1.dout_en_B}, 13'h0000);
        chk("flush_sq_d1", bus1.sq_dout, 13'h0000);
      end
      if (i == 7) chk("flush_hold_d3", {12'b0, bus3.dout_en_A}, 13'h0000);
      if (i == 8) chk("flush_resume_d3", {12'b0, bus3.dout_en_A}, 13'h0001);
    end

    rst = 1'b0;
    a_v = '0; b_v = '0; s_v = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
